// File: rtl/multicore_pkg.sv
// Shared types for the core's sequencing logic: forward selects, hazard FSM
// states and the per-stage destination tag carried down the shadow pipeline.
package multicore_pkg;

  // Tags are stored at this fixed width. Narrower register files zero-extend
  // into it, so NUM_REGS may be at most 2**REG_TAG_W.
  localparam int REG_TAG_W = 8;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MA   = 2'b01,
    FWD_WB   = 2'b10
  } t_fwd;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } t_haz_state;

  typedef struct packed {
    logic                 valid;
    logic [REG_TAG_W-1:0] rd;
    logic                 regwrite;
    logic                 load;
  } t_stage_tag;

  localparam t_stage_tag TAG_BUBBLE = '{valid: 1'b0, rd: '0, regwrite: 1'b0, load: 1'b0};

  // A stage's result is wanted by decode only if the operand is really read,
  // the stage writes a register, and that register is not the hardwired x0.
  function automatic logic tag_match(input logic                 valid,
                                     input logic                 regwrite,
                                     input logic [REG_TAG_W-1:0] rd,
                                     input logic [REG_TAG_W-1:0] rs,
                                     input logic                 use_rs);
    return use_rs & valid & regwrite & (rd != '0) & (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Match and forward-select logic for one decode source operand.
module hazard_fwd_sel
  import multicore_pkg::*;
(
  input  logic [REG_TAG_W-1:0] i_rs,
  input  logic                 i_use,
  input  t_stage_tag           i_ex_tag,
  input  t_stage_tag           i_ma_tag,
  input  t_stage_tag           i_wb_tag,
  output t_fwd                 o_fwd,
  output logic                 o_ex_hit,
  output logic                 o_ma_load_hit
);

  logic w_ma_hit;
  logic w_wb_hit;
  // Load flags of EX and WB do not influence this operand's decision.
  logic w_unused_load_bits;

  assign o_ex_hit = tag_match(i_ex_tag.valid, i_ex_tag.regwrite, i_ex_tag.rd, i_rs, i_use);
  assign w_ma_hit = tag_match(i_ma_tag.valid, i_ma_tag.regwrite, i_ma_tag.rd, i_rs, i_use);
  assign w_wb_hit = tag_match(i_wb_tag.valid, i_wb_tag.regwrite, i_wb_tag.rd, i_rs, i_use);

  // A load in MA has no data yet; that case is a stall, not a forward.
  assign o_ma_load_hit = w_ma_hit & i_ma_tag.load;

  assign w_unused_load_bits = i_ex_tag.load ^ i_wb_tag.load;

  // Youngest available producer wins: MA before WB, else the register file.
  always_comb begin
    o_fwd = FWD_NONE;
    if (w_ma_hit && !i_ma_tag.load) begin
      o_fwd = FWD_MA;
    end else if (w_wb_hit) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: shadow tags for EX/MA/WB, forward selects,
// stall/flush/hold generation, stall counter and sticky memory timeout.
module pipeline_hazard_ctrl
  import multicore_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic                        i_aclk,
  input  logic                        i_reset,
  input  logic [$clog2(NUM_REGS)-1:0] i_id_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] i_id_rs2,
  input  logic                        i_id_use_rs1,
  input  logic                        i_id_use_rs2,
  input  logic [$clog2(NUM_REGS)-1:0] i_id_rd,
  input  logic                        i_id_regwrite,
  input  logic                        i_id_memaccess,
  input  logic                        i_id_memwrite,
  input  logic                        i_id_jal,
  input  logic                        i_ex_redirect,
  input  logic                        i_dmem_ready,
  output logic [1:0]                  o_forward_a,
  output logic [1:0]                  o_forward_b,
  output logic                        o_stall,
  output logic                        o_flush_id,
  output logic                        o_flush_ex,
  output logic                        o_hold,
  output logic [31:0]                 o_stall_count,
  output logic                        o_mem_timeout
);

  localparam int            TO_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  t_stage_tag           r_ex_tag, r_ma_tag, r_wb_tag;
  // Memory-access flags travel beside the tags; stores wait on memory too.
  logic                 r_ex_mem, r_ma_mem;
  t_haz_state           r_state, w_state_next;
  logic [TO_W-1:0]      r_to_cnt, w_to_cnt_next;
  logic                 r_mem_timeout;
  logic [31:0]          r_stall_count;

  logic [REG_TAG_W-1:0] w_rs [2];
  logic                 w_use [2];
  t_fwd                 w_fwd [2];
  logic [1:0]           w_ex_hit;
  logic [1:0]           w_ma_load_hit;
  logic                 w_stall_need;
  logic                 w_wait_cond;
  logic                 w_hold;
  logic                 w_stall, w_flush_id, w_flush_ex;
  t_fwd                 w_fwd_a, w_fwd_b;

  assign w_rs[0]  = REG_TAG_W'(i_id_rs1);
  assign w_rs[1]  = REG_TAG_W'(i_id_rs2);
  assign w_use[0] = i_id_use_rs1;
  assign w_use[1] = i_id_use_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      hazard_fwd_sel u_sel (
        .i_rs          (w_rs[gi]),
        .i_use         (w_use[gi]),
        .i_ex_tag      (r_ex_tag),
        .i_ma_tag      (r_ma_tag),
        .i_wb_tag      (r_wb_tag),
        .o_fwd         (w_fwd[gi]),
        .o_ex_hit      (w_ex_hit[gi]),
        .o_ma_load_hit (w_ma_load_hit[gi])
      );
    end
  endgenerate

  assign w_stall_need = (|w_ex_hit) | (|w_ma_load_hit);
  assign w_wait_cond  = r_ma_tag.valid & r_ma_mem & ~i_dmem_ready;

  // Memory-wait FSM: next state and hold; hold starts in the same cycle the
  // unready access is seen and drops in the cycle memory completes.
  always_comb begin
    w_state_next = r_state;
    w_hold       = 1'b0;
    case (r_state)
      RUN: begin
        if (w_wait_cond) begin
          w_hold       = 1'b1;
          w_state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (i_dmem_ready) begin
          w_state_next = RUN;
        end else begin
          w_hold = 1'b1;
        end
      end
      default: w_state_next = RUN;
    endcase
    if (i_reset) begin
      w_hold = 1'b0;
    end
  end

  // Priority resolution: reset, hold, redirect, stall, then JAL.
  always_comb begin
    w_stall    = 1'b0;
    w_flush_id = 1'b0;
    w_flush_ex = 1'b0;
    w_fwd_a    = FWD_NONE;
    w_fwd_b    = FWD_NONE;
    if (!i_reset && !w_hold) begin
      w_fwd_a = w_fwd[0];
      w_fwd_b = w_fwd[1];
      if (i_ex_redirect) begin
        w_flush_id = 1'b1;
        w_flush_ex = 1'b1;
      end else if (w_stall_need) begin
        w_stall    = 1'b1;
        w_flush_ex = 1'b1;
      end else if (i_id_jal) begin
        w_flush_id = 1'b1;
      end
    end
  end

  // Timeout counter runs only while waiting and sticks at its limit.
  always_comb begin
    w_to_cnt_next = '0;
    if (r_state == MEM_WAIT) begin
      w_to_cnt_next = (r_to_cnt == TO_LIMIT) ? r_to_cnt : r_to_cnt + 1'b1;
    end
  end

  // Shadow tag pipeline: frozen on hold except WB, which drains to a bubble.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_ex_tag <= TAG_BUBBLE;
      r_ma_tag <= TAG_BUBBLE;
      r_wb_tag <= TAG_BUBBLE;
      r_ex_mem <= 1'b0;
      r_ma_mem <= 1'b0;
    end else if (w_hold) begin
      r_wb_tag <= TAG_BUBBLE;
    end else begin
      r_wb_tag <= r_ma_tag;
      r_ma_tag <= r_ex_tag;
      r_ma_mem <= r_ex_mem;
      if (w_flush_ex) begin
        r_ex_tag <= TAG_BUBBLE;
        r_ex_mem <= 1'b0;
      end else begin
        r_ex_tag <= '{valid: 1'b1, rd: REG_TAG_W'(i_id_rd), regwrite: i_id_regwrite,
                      load: i_id_memaccess & ~i_id_memwrite};
        r_ex_mem <= i_id_memaccess;
      end
    end
  end

  // FSM state, timeout counter and sticky timeout flag.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_state       <= RUN;
      r_to_cnt      <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_to_cnt <= w_to_cnt_next;
      if ((r_state == MEM_WAIT) && (w_to_cnt_next == TO_LIMIT)) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  // Saturating debug count of cycles lost to stalls or memory holds.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_stall_count <= '0;
    end else if ((w_stall | w_hold) && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_forward_a   = w_fwd_a;
  assign o_forward_b   = w_fwd_b;
  assign o_stall       = w_stall;
  assign o_flush_id    = w_flush_id;
  assign o_flush_ex    = w_flush_ex;
  assign o_hold        = w_hold;
  assign o_stall_count = i_reset ? 32'd0 : r_stall_count;
  assign o_mem_timeout = ~i_reset & r_mem_timeout;

endmodule
